// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                             |
// | Shared FIFO defaults and a status bundle for downstream monitors.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic                     underflow;
    logic [FIFO_ADDR_WIDTH:0] count;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem                                                             |
// | DEPTH x DATA_WIDTH register array, one sync write and one sync read. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Single-clock FIFO with occupancy count and overflow/underflow pulses.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] C_PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_rd_valid;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] w_mem_rd_data;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                       (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_wr_accept = wr_en && !w_full;
  assign w_rd_accept = rd_en && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_rd_accept) begin
        r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
        r_rd_valid <= 1'b1;
      end
      r_overflow  <= wr_en && w_full;
      r_underflow <= rd_en && w_empty;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_accept),
    .wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (w_rd_accept),
    .rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (w_mem_rd_data)
  );

  // Storage has no reset, so data_out reads as zero until the first read after reset.
  assign data_out  = r_rd_valid ? w_mem_rd_data : '0;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer that decouples a producer driving `wr_en`/`data_in` from a consumer driving `rd_en`/`data_out`. It sits directly downstream of the stimulus/producer stage and absorbs bursts. It reports occupancy and flags dropped writes (overflow) and dropped reads (underflow) so the surrounding logic and benches can detect protocol misuse.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width in bits.
- `DEPTH`, default 8: number of entries. Must be a power of two and ≥ 2.
- `ADDR_WIDTH`: localparam equal to `$clog2(DEPTH)`. Not overridable.

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset. Asserts immediately; is released synchronously to `clk`.
- `wr_en`  in  1: write request for this cycle.
- `data_in`  in  DATA_WIDTH: write data, sampled when `wr_en` is high.
- `rd_en`  in  1: read request for this cycle.
- `data_out`  out  DATA_WIDTH: registered read data.
- `full`  out  1: occupancy equals DEPTH.
- `empty`  out  1: occupancy equals 0.
- `count`  out  ADDR_WIDTH+1: current occupancy, range 0..DEPTH.
- `overflow`  out  1: one-cycle pulse indicating a write was dropped.
- `underflow`  out  1: one-cycle pulse indicating a read was dropped.

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are each ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits index storage; the MSB is a wrap bit.
  - Both pointers increment modulo 2·DEPTH.
  - `empty` = (pointers equal).
  - `full` = (index bits equal and wrap bits differ).
  - `count` = `wr_ptr − rd_ptr`, computed modulo 2^(ADDR_WIDTH+1).
- **Write accept:** a write is accepted when `wr_en && !full`. On the clock edge, `mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in` and `wr_ptr` increments.
- **Read accept:** a read is accepted when `rd_en && !empty`. On the clock edge, `data_out <= mem[rd_ptr index]` and `rd_ptr` increments.
- **Holding `data_out`:** `data_out` keeps its previous value on any cycle without an accepted read, including a dropped read.
- **Simultaneous read and write:** both are evaluated against the flags *before* the clock edge.
  - Not full and not empty: both are accepted and `count` is unchanged.
  - Full: the read is accepted, the write is dropped, and `overflow` pulses.
  - Empty: the write is accepted, the read is dropped, and `underflow` pulses. There is no fall-through; written data becomes readable in the next cycle.
- **Error pulses:** `overflow` is registered as `wr_en && full` and `underflow` as `rd_en && empty`. Each is high for exactly the one cycle after the offending request. Pulses are not sticky.
- **Reset values:** while `rst` is high:
  - `wr_ptr`, `rd_ptr`, `count`, `data_out`, `overflow` and `underflow` are 0.
  - `empty` = 1 and `full` = 0.
  - Storage contents are not reset and are undefined after reset.
- **Reset mid-operation:** `rst` discards all stored entries. A request in the same cycle as reset release is ignored.

## Timing
- **Write to visibility:** a write accepted at edge N produces `empty` = 0 and an updated `count` immediately after edge N. A read can be issued in cycle N+1.
- **Read latency:** 1 cycle. Data for a read accepted at edge N appears on `data_out` after edge N.
- **Flag timing:** `full`, `empty` and `count` are derived combinationally from the registered pointers and are glitch-free relative to `clk`.
- **Throughput:** one write and one read per cycle, sustained.
- **Error-pulse timing:** `overflow` and `underflow` are valid in the cycle after the request.

## Structure
- **Package:** the shared package `fifo_pkg` holds the default `DATA_WIDTH`/`DEPTH` constants and a `fifo_status_t` struct grouping {`full`, `empty`, `overflow`, `underflow`, `count`} for use by downstream monitors.
- **Sub-module:** one sub-module, `fifo_mem`. It is a DEPTH×DATA_WIDTH register array with one synchronous write port and one synchronous read port, and has no reset. Pointer, flag and error logic stay in `sync_fifo`.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `empty`=1, `full`=0, `count`=0, `data_out`=0, `overflow`=`underflow`=0.
- **Overflow:** write 0..9 on consecutive cycles with `rd_en`=0 → the first 8 are accepted. `full`=1 after the 8th write. `overflow` pulses on the two cycles following writes 9 and 10. `count`=8.
- **Underflow:** from full, read 10 times → `data_out` = 0..7 in order, one cycle after each accepted read. `empty`=1 after the 8th read. `underflow` pulses twice. `data_out` holds 7.
- **Simultaneous at mid-occupancy and at full:** with `count`=4, assert `wr_en` and `rd_en` for 6 cycles → `count` stays 4 and data order is preserved. At `count`=8 with both asserted → the read is accepted, `count`=7, and `overflow`=1.
- **Wrap-around:** stream 20 words (0x00..0x13), keeping occupancy between 1 and 7 → all 20 words are read back in order with no flag pulses, and the pointers wrap twice.
- **Reset mid-operation:** with `count`=5, assert `rst` asynchronously mid-cycle → `count`=0, `empty`=1 and `data_out`=0 without waiting for a clock edge. After release, the next write/read returns the new value, not stale data.
